// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: per-register write
// scoreboard, RAW/full stalls, and branch flush sequencing beside decode.
module pipeline_hazard_ctrl #(
  parameter int NREG      = 16,
  parameter int AW        = 4,
  parameter int MAXPEND   = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs1,
  input  logic [AW-1:0] d_rs2,
  input  logic [AW-1:0] d_rd,
  input  logic          d_use_rs1,
  input  logic          d_use_rs2,
  input  logic          d_use_rd,
  input  logic          d_wre,
  input  logic          e_branch_taken,
  input  logic          wb_valid,
  input  logic          wb_wre,
  input  logic [AW-1:0] wb_rd,
  output logic          issue,
  output logic          stall_f,
  output logic          stall_fd,
  output logic          flush_fd,
  output logic          bubble_de,
  output logic [1:0]    state,
  output logic          err_underflow
);

  localparam int CW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [1:0]      pend [NREG];
  logic            raw, full, hazard;
  logic            inc, dec;
  logic [NREG-1:0] inc_hit, dec_hit;

  assign state = state_q;

  // Hazard checks read only registered pend, so wb_* never reaches the stalls
  // combinationally; a retire at edge N frees decode from the cycle after N.
  assign raw = d_valid & ((d_use_rs1 & (pend[d_rs1] != 2'd0)) |
                          (d_use_rs2 & (pend[d_rs2] != 2'd0)) |
                          (d_use_rd  & (pend[d_rd]  != 2'd0)));
  assign full   = d_valid & d_wre & (pend[d_rd] == 2'(MAXPEND));
  assign hazard = raw | full;

  // Handshake: issue=1 means the decode instruction is captured by
  // DecodeExecute at the next rising edge; issue is never 1 while stalled,
  // flushing or in reset, and bubble_de is 1 whenever issue is 0.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    issue     = 1'b0;
    stall_f   = 1'b0;
    stall_fd  = 1'b0;
    flush_fd  = 1'b0;
    bubble_de = 1'b0;
    case (state_q)
      RUN: begin
        if (e_branch_taken) begin
          flush_fd  = 1'b1;
          bubble_de = 1'b1;
          if (FLUSH_CYC > 0) begin
            state_n = FLUSH;
            cnt_n   = CW'(FLUSH_CYC);
          end
        end else if (hazard) begin
          stall_f   = 1'b1;
          stall_fd  = 1'b1;
          bubble_de = 1'b1;
        end else begin
          issue     = d_valid;
          bubble_de = ~d_valid;
        end
      end
      FLUSH: begin
        flush_fd  = 1'b1;
        bubble_de = 1'b1;
        if (e_branch_taken) begin
          cnt_n = CW'(FLUSH_CYC);
        end else if (cnt_q <= CW'(1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
    if (!rst) begin
      issue     = 1'b0;
      stall_f   = 1'b0;
      stall_fd  = 1'b0;
      flush_fd  = 1'b1;
      bubble_de = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  assign inc = issue & d_wre;
  assign dec = wb_valid & wb_wre;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_hit[i] = inc & (d_rd == AW'(i));
      dec_hit[i] = dec & (wb_rd == AW'(i));
    end
  end

  // A matching issue and retire on one register cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= 2'd0;
      err_underflow <= 1'b0;
    end else begin
      if (dec && (pend[wb_rd] == 2'd0)) err_underflow <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        if (inc_hit[i] && !dec_hit[i] && (pend[i] != 2'd3))
          pend[i] <= pend[i] + 2'd1;
        else if (dec_hit[i] && !inc_hit[i] && (pend[i] != 2'd0))
          pend[i] <= pend[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic,
// all checked every cycle against a behavioural model of the scoreboard/flush.
module tb_pipeline_hazard_ctrl;

  localparam int NREG      = 16;
  localparam int AW        = 4;
  localparam int MAXPEND   = 3;
  localparam int FLUSH_CYC = 1;

  logic          clk;
  logic          rst;
  logic          d_valid;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic          d_use_rs1, d_use_rs2, d_use_rd, d_wre;
  logic          e_branch_taken;
  logic          wb_valid, wb_wre;
  logic [AW-1:0] wb_rd;
  logic          issue, stall_f, stall_fd, flush_fd, bubble_de;
  logic [1:0]    state;
  logic          err_underflow;

  pipeline_hazard_ctrl #(
    .NREG(NREG), .AW(AW), .MAXPEND(MAXPEND), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_use_rd(d_use_rd),
    .d_wre(d_wre), .e_branch_taken(e_branch_taken),
    .wb_valid(wb_valid), .wb_wre(wb_wre), .wb_rd(wb_rd),
    .issue(issue), .stall_f(stall_f), .stall_fd(stall_fd),
    .flush_fd(flush_fd), .bubble_de(bubble_de), .state(state),
    .err_underflow(err_underflow)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int         pend_m [NREG];
  int         flush_left;
  bit         err_m;
  bit         e_issue;
  logic [6:0] exp_q[$];
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit model_hazard();
    bit h;
    h = 1'b0;
    if (d_valid) begin
      if (d_use_rs1 && pend_m[d_rs1] > 0) h = 1'b1;
      if (d_use_rs2 && pend_m[d_rs2] > 0) h = 1'b1;
      if (d_use_rd  && pend_m[d_rd]  > 0) h = 1'b1;
      if (d_wre && pend_m[d_rd] >= MAXPEND) h = 1'b1;
    end
    return h;
  endfunction

  // Expected vector: {state[1:0], issue, stall_f, stall_fd, flush_fd, bubble_de}
  task automatic model_expect();
    bit i_e, sf, sfd, ff, bd;
    i_e = 0; sf = 0; sfd = 0; ff = 0; bd = 0;
    if (!rst) begin
      ff = 1; bd = 1;
    end else if (flush_left > 0 || e_branch_taken) begin
      ff = 1; bd = 1;
    end else if (model_hazard()) begin
      sf = 1; sfd = 1; bd = 1;
    end else begin
      i_e = d_valid; bd = !d_valid;
    end
    e_issue = i_e;
    exp_q.push_back({(flush_left > 0) ? 2'b01 : 2'b00, i_e, sf, sfd, ff, bd});
  endtask

  task automatic model_edge();
    bit inc, dec;
    if (!rst) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      flush_left = 0;
      err_m      = 0;
      return;
    end
    inc = e_issue && d_wre;
    dec = wb_valid && wb_wre;
    if (dec && pend_m[wb_rd] == 0) err_m = 1;
    if (!(inc && dec && d_rd == wb_rd)) begin
      if (inc) pend_m[d_rd] = pend_m[d_rd] + 1;
      if (dec && pend_m[wb_rd] > 0) pend_m[wb_rd] = pend_m[wb_rd] - 1;
    end
    if (e_branch_taken) flush_left = FLUSH_CYC;
    else if (flush_left > 0) flush_left = flush_left - 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cycle();
    @(negedge clk);
    rst = 1'b1; d_valid = 0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
    d_use_rs1 = 0; d_use_rs2 = 0; d_use_rd = 0; d_wre = 0;
    e_branch_taken = 0; wb_valid = 0; wb_wre = 0; wb_rd = '0;
  endtask

  task automatic verify();
    logic [6:0] exp;
    #1;
    model_expect();
    exp = exp_q.pop_front();
    check("state",     32'(state),     32'(exp[6:5]));
    check("issue",     32'(issue),     32'(exp[4]));
    check("stall_f",   32'(stall_f),   32'(exp[3]));
    check("stall_fd",  32'(stall_fd),  32'(exp[2]));
    check("flush_fd",  32'(flush_fd),  32'(exp[1]));
    check("bubble_de", 32'(bubble_de), 32'(exp[0]));
    check("err_underflow", 32'(err_underflow), 32'(err_m));
    for (int i = 0; i < NREG; i++)
      check($sformatf("pend[%0d]", i), 32'(dut.pend[i]), 32'(pend_m[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic set_write(input int rd);
    d_valid = 1; d_wre = 1; d_rd = AW'(rd);
  endtask

  task automatic set_retire(input int rd);
    wb_valid = 1; wb_wre = 1; wb_rd = AW'(rd);
  endtask

  task automatic set_add(input int rs1, input int rs2, input int rd);
    d_valid = 1; d_wre = 1; d_rd = AW'(rd);
    d_rs1 = AW'(rs1); d_rs2 = AW'(rs2); d_use_rs1 = 1; d_use_rs2 = 1;
  endtask

  task automatic idle_cycle();
    begin_cycle(); verify(); tick();
  endtask

  function automatic logic [AW-1:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cand[$];
    n_checks = 0; n_pass = 0;
    foreach (pend_m[i]) pend_m[i] = 0;
    flush_left = 0; err_m = 0; e_issue = 0;

    // Reset held for two cycles with decode presenting an instruction.
    for (int c = 0; c < 2; c++) begin
      begin_cycle(); rst = 0; set_write(1); e_branch_taken = 1;
      verify();
      check("rst_flush_fd", 32'(flush_fd), 32'd1);
      check("rst_issue", 32'(issue), 32'd0);
      tick();
    end
    begin_cycle(); verify();
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_flush_fd", 32'(flush_fd), 32'd0);
    tick();

    // RAW stall: mov r1, then add using r1 waits for r1's retire.
    begin_cycle(); set_write(1); verify(); check("t2_mov_issue", 32'(issue), 32'd1); tick();
    for (int c = 0; c < 2; c++) begin
      begin_cycle(); set_add(1, 2, 4); verify();
      check("t2_stall_f", 32'(stall_f), 32'd1); tick();
    end
    begin_cycle(); set_add(1, 2, 4); set_retire(1); verify();
    check("t2_stall_retire_cycle", 32'(stall_fd), 32'd1); tick();
    begin_cycle(); set_add(1, 2, 4); verify();
    check("t2_issue_after_retire", 32'(issue), 32'd1); tick();
    begin_cycle(); set_retire(4); verify(); tick();

    // Simultaneous issue and retire on r2.
    begin_cycle(); set_write(2); verify(); tick();
    begin_cycle(); set_write(2); set_retire(2); verify(); tick();
    begin_cycle(); set_retire(2); verify();
    check("t3_pend2_held", 32'(dut.pend[2]), 32'd1); tick();
    begin_cycle(); verify(); check("t3_pend2_clear", 32'(dut.pend[2]), 32'd0); tick();

    // Counter saturation on r3.
    for (int c = 0; c < 3; c++) begin
      begin_cycle(); set_write(3); verify(); tick();
    end
    begin_cycle(); set_write(3); verify();
    check("t4_pend3_full", 32'(dut.pend[3]), 32'd3);
    check("t4_full_stall", 32'(stall_f), 32'd1); tick();
    begin_cycle(); set_write(3); set_retire(3); verify(); tick();
    begin_cycle(); set_write(3); verify(); check("t4_issue", 32'(issue), 32'd1); tick();
    begin_cycle(); verify(); check("t4_pend3_back", 32'(dut.pend[3]), 32'd3); tick();
    for (int c = 0; c < 3; c++) begin
      begin_cycle(); set_retire(3); verify(); tick();
    end

    // Branch while stalled on r1.
    begin_cycle(); set_write(1); verify(); tick();
    begin_cycle(); set_add(1, 2, 5); verify(); check("t5_stalled", 32'(stall_f), 32'd1); tick();
    begin_cycle(); set_add(1, 2, 5); e_branch_taken = 1; verify();
    check("t5_flush_fd", 32'(flush_fd), 32'd1);
    check("t5_stall_f", 32'(stall_f), 32'd0);
    check("t5_issue", 32'(issue), 32'd0); tick();
    begin_cycle(); set_add(1, 2, 5); verify();
    check("t5_state_flush", 32'(state), 32'd1);
    check("t5_no_issue_in_flush", 32'(issue), 32'd0); tick();
    begin_cycle(); verify();
    check("t5_state_run", 32'(state), 32'd0);
    check("t5_pend1_kept", 32'(dut.pend[1]), 32'd1); tick();
    begin_cycle(); set_retire(1); verify(); tick();

    // Underflow on r5, sticky until reset.
    begin_cycle(); set_retire(5); verify(); tick();
    begin_cycle(); verify();
    check("t6_err_set", 32'(err_underflow), 32'd1);
    check("t6_pend5_zero", 32'(dut.pend[5]), 32'd0); tick();
    for (int c = 0; c < 3; c++) idle_cycle();
    begin_cycle(); verify(); check("t6_err_sticky", 32'(err_underflow), 32'd1); tick();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      begin_cycle();
      rst            = ($urandom_range(0, 99) != 0);
      d_valid        = ($urandom_range(0, 3) != 0);
      d_rs1          = rand_reg();
      d_rs2          = rand_reg();
      d_rd           = rand_reg();
      d_use_rs1      = 1'($urandom_range(0, 1));
      d_use_rs2      = 1'($urandom_range(0, 1));
      d_use_rd       = ($urandom_range(0, 3) == 0);
      d_wre          = ($urandom_range(0, 3) != 0);
      e_branch_taken = ($urandom_range(0, 11) == 0);
      wb_valid       = ($urandom_range(0, 2) != 0);
      wb_wre         = ($urandom_range(0, 7) != 0);
      cand.delete();
      for (int i = 0; i < NREG; i++) if (pend_m[i] > 0) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) != 0)
        wb_rd = AW'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wb_rd = rand_reg();
      verify();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
